// File: rtl/updi_unlock_sequencer.sv
// updi_unlock_sequencer: UPDI link init and NVMPROG unlock sequencer.
// Drives updi_interface and the PHY break while busy; reports a failure code.
module updi_unlock_sequencer #(
   parameter int unsigned POLL_LIMIT    = 16,
   parameter int unsigned POLL_GAP      = 1024,
   parameter logic [63:0] KEY_NVMPROG   = 64'h4E564D50726F6720,
   parameter int unsigned BREAK_TIMEOUT = 1 << 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [2:0]  err_code,
   output logic        dbl_break_start,
   input  logic        dbl_break_done,
   output logic [1:0]  instr_op,
   output logic [3:0]  instr_cs_addr,
   output logic [63:0] instr_data,
   output logic [3:0]  instr_data_len,
   output logic        tx_start,
   input  logic        tx_ready,
   output logic        rx_start,
   output logic [3:0]  rx_n_bytes,
   input  logic        rx_ready,
   input  logic        ack_error,
   input  logic [7:0]  rx_fifo_data,
   output logic        rx_fifo_rd_en,
   input  logic        rx_fifo_empty
);

   localparam int unsigned TMAX =
      (BREAK_TIMEOUT > POLL_GAP) ? BREAK_TIMEOUT : POLL_GAP;
   localparam int unsigned TW = $clog2(TMAX + 1);
   localparam int unsigned PW = $clog2(POLL_LIMIT + 1);

   localparam logic [1:0] OP_LDCS = 2'd0;
   localparam logic [1:0] OP_STCS = 2'd1;
   localparam logic [1:0] OP_KEY  = 2'd2;

   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_ACK   = 3'd1;
   localparam logic [2:0] ERR_KEY   = 3'd2;
   localparam logic [2:0] ERR_SYS   = 3'd3;
   localparam logic [2:0] ERR_BREAK = 3'd4;

   typedef enum logic [3:0] {
      S_IDLE,
      S_BRK_PULSE,
      S_BRK_WAIT,
      S_TX_LAUNCH,
      S_TX_WAIT,
      S_RX_LAUNCH,
      S_RX_WAIT,
      S_FIFO_WAIT,
      S_POP,
      S_GAP,
      S_DONE,
      S_ERROR
   } state_e;

   // Which instruction the shared TX/RX phases are working on.
   typedef enum logic [2:0] {
      ST_CTRLB,
      ST_KEY,
      ST_KPOLL,
      ST_RSTSET,
      ST_RSTCLR,
      ST_SPOLL
   } step_e;

   state_e          state_q, state_d;
   step_e           step_q, step_d;
   step_e           next_step;
   logic [TW-1:0]   timer_q, timer_d;
   logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
   logic [PW-1:0]   poll_inc;
   logic [2:0]      err_code_q, err_code_d;
   logic            busy_st;
   logic            is_poll;
   logic            poll_ok;
   logic [7:0]      poll_mask;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         step_q     <= ST_CTRLB;
         timer_q    <= '0;
         poll_cnt_q <= '0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         timer_q    <= timer_d;
         poll_cnt_q <= poll_cnt_d;
         err_code_q <= err_code_d;
      end
   end

   always_comb begin
      busy_st = !(state_q inside {S_IDLE, S_DONE, S_ERROR});
      is_poll = (step_q == ST_KPOLL) || (step_q == ST_SPOLL);
      poll_mask = (step_q == ST_KPOLL) ? 8'h10 : 8'h08;
      poll_ok = |(rx_fifo_data & poll_mask);
      poll_inc = poll_cnt_q + PW'(1);
   end

   always_comb begin
      next_step = step_q;
      unique case (step_q)
         ST_CTRLB:  next_step = ST_KEY;
         ST_KEY:    next_step = ST_KPOLL;
         ST_RSTSET: next_step = ST_RSTCLR;
         ST_RSTCLR: next_step = ST_SPOLL;
         default:   next_step = step_q;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      timer_d    = timer_q;
      poll_cnt_d = poll_cnt_q;
      err_code_d = err_code_q;
      // A bad ACK wins over anything else completing this cycle.
      if (busy_st && ack_error) begin
         state_d    = S_ERROR;
         err_code_d = ERR_ACK;
      end else begin
         unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  state_d    = S_BRK_PULSE;
                  err_code_d = ERR_NONE;
                  poll_cnt_d = '0;
               end
            end
            S_BRK_PULSE: begin
               state_d = S_BRK_WAIT;
               timer_d = '0;
            end
            S_BRK_WAIT: begin
               if (dbl_break_done) begin
                  state_d = S_TX_LAUNCH;
                  step_d  = ST_CTRLB;
               end else if (timer_q == TW'(BREAK_TIMEOUT)) begin
                  state_d    = S_ERROR;
                  err_code_d = ERR_BREAK;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            S_TX_LAUNCH: begin
               if (tx_ready) state_d = S_TX_WAIT;
            end
            S_TX_WAIT: begin
               if (tx_ready) begin
                  if (is_poll) begin
                     state_d = S_RX_LAUNCH;
                  end else begin
                     state_d    = S_TX_LAUNCH;
                     step_d     = next_step;
                     poll_cnt_d = '0;
                  end
               end
            end
            S_RX_LAUNCH: begin
               if (rx_ready) state_d = S_RX_WAIT;
            end
            S_RX_WAIT: begin
               if (rx_ready) state_d = S_FIFO_WAIT;
            end
            S_FIFO_WAIT: begin
               if (!rx_fifo_empty) state_d = S_POP;
            end
            S_POP: begin
               if (poll_ok) begin
                  if (step_q == ST_KPOLL) begin
                     state_d = S_TX_LAUNCH;
                     step_d  = ST_RSTSET;
                  end else begin
                     state_d = S_DONE;
                  end
               end else if (poll_inc == PW'(POLL_LIMIT)) begin
                  state_d    = S_ERROR;
                  poll_cnt_d = poll_inc;
                  err_code_d = (step_q == ST_KPOLL) ? ERR_KEY : ERR_SYS;
               end else begin
                  state_d    = S_GAP;
                  poll_cnt_d = poll_inc;
                  timer_d    = '0;
               end
            end
            S_GAP: begin
               if (timer_q == TW'(POLL_GAP - 1)) begin
                  state_d = S_TX_LAUNCH;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      busy            = busy_st;
      done            = (state_q == S_DONE);
      error           = (state_q == S_ERROR);
      err_code        = err_code_q;
      dbl_break_start = (state_q == S_BRK_PULSE);
      tx_start        = (state_q == S_TX_LAUNCH) && tx_ready;
      rx_start        = (state_q == S_RX_LAUNCH) && rx_ready;
      rx_fifo_rd_en   = (state_q == S_POP);
      rx_n_bytes      = 4'd1;
      instr_op        = OP_LDCS;
      instr_cs_addr   = 4'h0;
      instr_data      = 64'h0;
      instr_data_len  = 4'd0;
      // Held constant from launch through completion.
      if (state_q == S_TX_LAUNCH || state_q == S_TX_WAIT) begin
         unique case (step_q)
            ST_CTRLB: begin
               instr_op       = OP_STCS;
               instr_cs_addr  = 4'h3;
               instr_data     = 64'h08;
               instr_data_len = 4'd1;
            end
            ST_KEY: begin
               instr_op       = OP_KEY;
               instr_data     = KEY_NVMPROG;
               instr_data_len = 4'd8;
            end
            ST_KPOLL: begin
               instr_op      = OP_LDCS;
               instr_cs_addr = 4'h7;
            end
            ST_RSTSET: begin
               instr_op       = OP_STCS;
               instr_cs_addr  = 4'h8;
               instr_data     = 64'h59;
               instr_data_len = 4'd1;
            end
            ST_RSTCLR: begin
               instr_op       = OP_STCS;
               instr_cs_addr  = 4'h8;
               instr_data     = 64'h00;
               instr_data_len = 4'd1;
            end
            ST_SPOLL: begin
               instr_op      = OP_LDCS;
               instr_cs_addr = 4'hB;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_updi_unlock_sequencer.sv
// tb_updi_unlock_sequencer: table-driven unlock runs against a small
// updi_interface/PHY model with an instruction scoreboard.
module tb_updi_unlock_sequencer;

   localparam int PL = 4;
   localparam int PG = 20;
   localparam int BT = 64;
   localparam logic [63:0] KEY = 64'h4E564D50726F6720;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, error;
   logic [2:0]  err_code;
   logic        dbl_break_start;
   logic        dbl_break_done = 1'b0;
   logic [1:0]  instr_op;
   logic [3:0]  instr_cs_addr;
   logic [63:0] instr_data;
   logic [3:0]  instr_data_len;
   logic        tx_start;
   logic        tx_ready = 1'b1;
   logic        rx_start;
   logic [3:0]  rx_n_bytes;
   logic        rx_ready = 1'b1;
   logic        ack_error = 1'b0;
   logic [7:0]  rx_fifo_data = 8'h00;
   logic        rx_fifo_rd_en;
   logic        rx_fifo_empty = 1'b1;

   updi_unlock_sequencer #(
      .POLL_LIMIT(PL), .POLL_GAP(PG), .KEY_NVMPROG(KEY),
      .BREAK_TIMEOUT(BT)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .busy(busy), .done(done), .error(error), .err_code(err_code),
      .dbl_break_start(dbl_break_start),
      .dbl_break_done(dbl_break_done),
      .instr_op(instr_op), .instr_cs_addr(instr_cs_addr),
      .instr_data(instr_data), .instr_data_len(instr_data_len),
      .tx_start(tx_start), .tx_ready(tx_ready),
      .rx_start(rx_start), .rx_n_bytes(rx_n_bytes),
      .rx_ready(rx_ready), .ack_error(ack_error),
      .rx_fifo_data(rx_fifo_data), .rx_fifo_rd_en(rx_fifo_rd_en),
      .rx_fifo_empty(rx_fifo_empty)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [1:0]  op;
      logic [3:0]  cs;
      logic [3:0]  len;
      logic [63:0] data;
   } instr_t;

   typedef struct {
      string       nm;
      logic [31:0] kresp;
      int          nk;
      logic [31:0] sresp;
      int          ns;
      bit          exp_done;
      logic [2:0]  exp_code;
      int          exp_kr;
      int          exp_sr;
      int          lat;
   } vec_t;

   instr_t     sb[$];
   logic [7:0] kq[$];
   logic [7:0] sq[$];

   int n_vec = 0;
   int n_fail = 0;

   int lat = 3;
   int brk_delay = 5;
   bit inject_ack = 0;
   int n_tx = 0;
   int n_kreads = 0;
   int n_sreads = 0;
   int n_breaks = 0;
   int brk_cyc = 0;
   int last_ldcs_cyc = -1;
   logic [3:0] last_ldcs_cs = 4'h0;

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", nm, act, exp);
      end
   endtask

   function automatic instr_t mk(input logic [1:0] op, input logic [3:0] cs,
                                 input logic [3:0] len,
                                 input logic [63:0] data);
      instr_t r;
      r.op = op;
      r.cs = cs;
      r.len = len;
      r.data = data;
      return r;
   endfunction

   // Interface / PHY model: observe on negedge, drive just after posedge.
   initial begin : model
      instr_t     got;
      int         tx_wait;
      int         rx_wait;
      int         brk_cnt;
      bit         pend;
      logic [7:0] pend_byte;
      bit         f_empty;
      logic [7:0] f_data;
      bit         nb_done;
      bit         nack;
      logic [3:0] last_cs;
      tx_wait = 0; rx_wait = 0; brk_cnt = 0; pend = 0;
      pend_byte = 8'h00; f_empty = 1; f_data = 8'h00;
      last_cs = 4'h0;
      forever begin
         @(negedge clk);
         nb_done = 0;
         nack = 0;
         if (rst) begin
            tx_wait = 0; rx_wait = 0; brk_cnt = 0;
            pend = 0; f_empty = 1;
         end else begin
            if (dbl_break_start) begin
               brk_cnt = brk_delay;
               n_breaks++;
            end else if (brk_cnt > 0) begin
               brk_cnt--;
               if (brk_cnt == 0) nb_done = 1;
            end
            if (tx_start && tx_ready) begin
               got = {instr_op, instr_cs_addr, instr_data_len, instr_data};
               tx_wait = lat;
               n_tx++;
               if (sb.size() == 0) begin
                  n_vec++;
                  n_fail++;
                  $display("FAIL tx_unexpected: got %0h required none", got);
               end else begin
                  check("tx_instr", got, sb.pop_front());
               end
               if (got.op == 2'd0) begin
                  last_cs = got.cs;
                  if (last_ldcs_cyc >= 0 && last_ldcs_cs == got.cs)
                     check("poll_gap", (cyc - last_ldcs_cyc) >= PG + 1, 1);
                  last_ldcs_cyc = cyc;
                  last_ldcs_cs = got.cs;
               end
               if (inject_ack && got.op == 2'd2) nack = 1;
            end else if (tx_wait > 0) begin
               tx_wait--;
            end
            if (rx_start && rx_ready) begin
               check("rx_n_bytes", rx_n_bytes, 1);
               rx_wait = lat;
               pend = 1;
               if (last_cs == 4'h7) begin
                  n_kreads++;
                  pend_byte = (kq.size() > 0) ? kq.pop_front() : 8'h00;
               end else begin
                  n_sreads++;
                  pend_byte = (sq.size() > 0) ? sq.pop_front() : 8'h00;
               end
            end else if (rx_wait > 0) begin
               rx_wait--;
            end
            if (pend && rx_wait == 0) begin
               pend = 0;
               f_empty = 0;
               f_data = pend_byte;
            end else if (rx_fifo_rd_en) begin
               f_empty = 1;
            end
         end
         @(posedge clk);
         #1;
         tx_ready = (tx_wait == 0);
         rx_ready = (rx_wait == 0);
         rx_fifo_empty = f_empty;
         rx_fifo_data = f_data;
         dbl_break_done = nb_done;
         ack_error = nack;
         if (nb_done) brk_cyc = cyc;
      end
   end

   task automatic prep(input vec_t v);
      sb.delete();
      kq.delete();
      sq.delete();
      for (int i = 0; i < v.nk; i++) kq.push_back(v.kresp[8*i +: 8]);
      for (int i = 0; i < v.ns; i++) sq.push_back(v.sresp[8*i +: 8]);
      lat = v.lat;
      n_kreads = 0;
      n_sreads = 0;
      n_breaks = 0;
      n_tx = 0;
      last_ldcs_cyc = -1;
      sb.push_back(mk(2'd1, 4'h3, 4'd1, 64'h08));
      sb.push_back(mk(2'd2, 4'h0, 4'd8, KEY));
      for (int i = 0; i < v.exp_kr; i++)
         sb.push_back(mk(2'd0, 4'h7, 4'd0, 64'h0));
      if (v.exp_code != 3'd2) begin
         sb.push_back(mk(2'd1, 4'h8, 4'd1, 64'h59));
         sb.push_back(mk(2'd1, 4'h8, 4'd1, 64'h00));
         for (int i = 0; i < v.exp_sr; i++)
            sb.push_back(mk(2'd0, 4'hB, 4'd0, 64'h0));
      end
   endtask

   task automatic kick(input string nm);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({nm, "_start"}, {busy, done, error, err_code}, {3'b100, 3'd0});
   endtask

   task automatic wait_end(input string nm, output int endcyc);
      bit ok;
      ok = 0;
      endcyc = 0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (done || error) begin
            ok = 1;
            endcyc = cyc;
            break;
         end
      end
      check({nm, "_end_reached"}, ok, 1);
   endtask

   task automatic finish_vec(input vec_t v);
      int ec;
      wait_end(v.nm, ec);
      check({v.nm, "_done"}, done, v.exp_done);
      check({v.nm, "_error"}, error, !v.exp_done);
      check({v.nm, "_busy"}, busy, 0);
      check({v.nm, "_code"}, err_code, v.exp_code);
      check({v.nm, "_key_reads"}, n_kreads, v.exp_kr);
      check({v.nm, "_sys_reads"}, n_sreads, v.exp_sr);
      check({v.nm, "_sb_left"}, sb.size(), 0);
      if (v.lat == 1) check({v.nm, "_latency"}, (ec - brk_cyc) <= 40, 1);
   endtask

   initial begin : main
      vec_t tbl[6];
      vec_t v;
      int   ec;
      int   ntx;
      bit   ok;

      tbl[0] = '{"nominal", 32'h10, 1, 32'h08, 1, 1, 3'd0, 1, 1, 1};
      tbl[1] = '{"key_timeout", 32'h0, 0, 32'h0, 0, 0, 3'd2, 4, 0, 3};
      tbl[2] = '{"sys_slow", 32'h10, 1, 32'h00080000, 3, 1, 3'd0, 1, 3, 3};
      tbl[3] = '{"sys_timeout", 32'h10, 1, 32'h0, 0, 0, 3'd3, 1, 4, 3};
      tbl[4] = '{"key_slow", 32'h0010EF00, 3, 32'h08, 1, 1, 3'd0, 3, 1, 3};
      tbl[5] = '{"key_at_limit", 32'h10000000, 4, 32'hFF, 1, 1, 3'd0, 4, 1, 2};

      repeat (3) @(negedge clk);
      check("reset_outputs",
            {busy, done, error, err_code, dbl_break_start, tx_start,
             rx_start, rx_fifo_rd_en, instr_op, instr_cs_addr,
             instr_data, instr_data_len}, 0);
      rst = 1'b0;

      for (int t = 0; t < 6; t++) begin
         prep(tbl[t]);
         kick(tbl[t].nm);
         finish_vec(tbl[t]);
      end

      // ack_error during SEND_KEY
      v = tbl[0];
      v.nm = "ack_key";
      v.lat = 3;
      prep(v);
      sb.delete();
      sb.push_back(mk(2'd1, 4'h3, 4'd1, 64'h08));
      sb.push_back(mk(2'd2, 4'h0, 4'd8, KEY));
      inject_ack = 1;
      kick("ack_key");
      ok = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (ack_error) begin
            ok = 1;
            break;
         end
      end
      check("ack_seen", ok, 1);
      @(negedge clk);
      check("ack_next_cycle", {error, err_code, busy}, {1'b1, 3'd1, 1'b0});
      ntx = n_tx;
      repeat (40) @(negedge clk);
      check("ack_no_more_tx", n_tx, ntx);
      check("ack_sb_left", sb.size(), 0);
      inject_ack = 0;

      // start pulsed mid-sequence is ignored
      v = tbl[0];
      v.nm = "mid_start";
      v.lat = 3;
      prep(v);
      kick("mid_start");
      repeat (12) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      finish_vec(v);
      check("mid_start_breaks", n_breaks, 1);

      // asynchronous reset during KEY_POLL, then rerun
      prep(tbl[1]);
      kick("rst_kpoll");
      ok = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (n_kreads >= 1) begin
            ok = 1;
            break;
         end
      end
      check("rst_kpoll_reached", ok, 1);
      check("rst_pre_busy", busy, 1);
      #3 rst = 1'b1;
      #1 check("rst_async_outputs",
               {busy, done, error, err_code, dbl_break_start, tx_start,
                rx_start, rx_fifo_rd_en, instr_op, instr_cs_addr,
                instr_data, instr_data_len}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      v = tbl[0];
      v.nm = "after_rst";
      v.lat = 3;
      prep(v);
      kick("after_rst");
      finish_vec(v);

      // PHY never finishes the break
      prep(tbl[0]);
      sb.delete();
      brk_delay = -1;
      kick("brk_timeout");
      wait_end("brk_timeout", ec);
      check("brk_timeout_code", {error, err_code}, {1'b1, 3'd4});
      check("brk_timeout_no_tx", n_tx, 0);
      brk_delay = 5;

      // restart from ERROR
      v = tbl[0];
      v.nm = "restart";
      prep(v);
      kick("restart");
      finish_vec(v);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/updi_unlock_sequencer.md
Name: updi_unlock_sequencer

Overview:
Sequences the UPDI interface/PHY through link init and NVMPROG unlock: double break, CTRLB setup, KEY, key-status poll, target reset pulse, then a system-status poll until NVMPROG is entered. Sits between the programmer's top-level FSM (start/busy/done) and updi_interface and the PHY double-break control. It owns those resources only while busy. Poll loops are bounded, and failures report a code.

Parameters:
POLL_LIMIT, 16, max LDCS status reads per poll phase before timeout
POLL_GAP, 1024, idle clk cycles between successive status reads
KEY_NVMPROG, 64'h4E564D50726F6720, key bytes ("NVMProg "), byte 0 = bits [7:0] sent first

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  begin sequence (sampled in IDLE/DONE/ERROR only)
busy  out  1  sequence in progress
done  out  1  unlock succeeded; held until next start
error  out  1  sequence failed; held until next start
err_code  out  3  0 none, 1 ack_error, 2 key-status timeout, 3 sys-status timeout, 4 break failure
dbl_break_start  out  1  one-cycle pulse to PHY
dbl_break_done  in  1  PHY break complete pulse
instr_op  out  2  0 LDCS, 1 STCS, 2 KEY
instr_cs_addr  out  4  CS register address
instr_data  out  64  STCS byte in [7:0]; KEY bytes little-endian
instr_data_len  out  4  bytes in instr_data (STCS 1, KEY 8, LDCS 0)
tx_start  out  1  one-cycle instruction launch
tx_ready  in  1  interface idle / TX accepted
rx_start  out  1  one-cycle receive launch
rx_n_bytes  out  4  bytes to receive (always 1)
rx_ready  in  1  interface RX idle
ack_error  in  1  interface reported missing/bad ACK
rx_fifo_data  in  8  received byte
rx_fifo_rd_en  out  1  pop received byte
rx_fifo_empty  in  1  RX output FIFO empty

Behaviour:
- Reset: state IDLE; busy, done, error, dbl_break_start, tx_start, rx_start, rx_fifo_rd_en = 0; err_code = 0; instr_* = 0; poll counters = 0.
- start accepted in IDLE/DONE/ERROR: clears done/error/err_code, asserts busy from the next cycle, and enters BREAK. start while busy is ignored.
- Transaction rule: tx_start/rx_start are asserted only when the matching ready is 1 and last one cycle. Acceptance is start&ready on that cycle. Completion is the first later cycle with ready=1; the interface guarantees ready=0 on the cycle after acceptance. instr_* stay stable from launch until completion.
- States, in order:
  - BREAK: pulse dbl_break_start, then wait for dbl_break_done. A wait longer than 2^20 cycles goes to ERROR with code 4.
  - SET_CTRLB: STCS cs 0x3, data 0x08 (collision detect off).
  - SEND_KEY: KEY, 8 bytes KEY_NVMPROG.
  - KEY_POLL: LDCS cs 0x7, rx 1 byte, wait for !rx_fifo_empty, pop with a 1-cycle rx_fifo_rd_en. If bit 4 = 1, go to RST_SET. Otherwise increment the count. If count = POLL_LIMIT, go to ERROR with code 2. Else wait POLL_GAP cycles and re-read.
  - RST_SET: STCS cs 0x8, data 0x59.
  - RST_CLR: STCS cs 0x8, data 0x00.
  - SYS_POLL: same as KEY_POLL with cs 0xB, bit 3, error code 3. Success goes to DONE.
  - DONE: busy = 0, done = 1.
  - ERROR: busy = 0, error = 1.
- ack_error=1 in any busy state goes to ERROR with code 1 on the next cycle. It takes priority over a same-cycle completion or poll success.
- The poll counter resets on entry to each poll phase. The first read counts as 1, so exactly POLL_LIMIT reads are issued before timeout.
- Gap counter: POLL_GAP cycles between completion of the pop and the next tx_start opportunity.
- Reset mid-sequence returns to IDLE immediately (asynchronous). Launches are never retried; bus recovery is the caller's job via a new start (which re-breaks).
- Latency with an ideal interface (ready restores 1 cycle after acceptance, byte available immediately, both polls pass on the first read): done asserts at most 40 cycles after dbl_break_done.

Test Plan:
- Nominal: model ACKs all; KEY_STATUS returns 0x10, SYS_STATUS 0x08 -> TX sequence STCS3/0x08, KEY(20 67 6F 72 50 4D 56 4E), LDCS7, STCS8/0x59, STCS8/0x00, LDCSB; done=1, error=0, busy falls the same cycle.
- Key timeout: POLL_LIMIT=4, KEY_STATUS always 0x00 -> exactly 4 LDCS7 spaced ≥POLL_GAP cycles; error=1, err_code=2; no STCS8 issued.
- Slow sys poll: SYS_STATUS 0x00,0x00,0x08 -> 3 LDCSB reads, done=1. With POLL_LIMIT=2 -> err_code=3.
- ack_error pulsed during SEND_KEY -> next cycle error=1, err_code=1; no further tx_start.
- start pulsed mid-sequence is ignored. rst asserted during KEY_POLL -> all outputs 0 asynchronously; a later start reruns from BREAK.
- Restart from ERROR: start clears error/err_code within 1 cycle; the nominal run then completes with done=1.
